lbp_frame_host: RTL and testbench
=================================

// Module: lbp_frame_host
// PURPOSE
//  Host/memory side of the gray-image / LBP-result interface driven by the LBP engine.
//  Buffers one gray frame loaded by the system and serves it on gray_ready/gray_req/gray_addr/gray_data.
//  Captures LBP results written on lbp_valid/lbp_addr/lbp_data and detects finish.
//  Exposes the result frame through a synchronous readback port.
// PARAMETERS
//  IMG_W   128  frame width in pixels
//  IMG_H   128  frame height in pixels
//  ADDR_W  14   pixel address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  DATA_W  8    pixel width
// PORTS
//  clk         in   1       clock; all logic on rising edge
//  reset       in   1       synchronous, active-high reset
//  start       in   1       pulse: begin frame load (honoured in IDLE only)
//  load_valid  in   1       load beat valid
//  load_data   in   DATA_W  gray pixel, raster order (x fastest)
//  load_ready  out  1       high in LOAD
//  gray_ready  out  1       high in SERVE: frame available to engine
//  gray_req    in   1       engine read request
//  gray_addr   in   ADDR_W  engine read address
//  gray_data   out  DATA_W  pixel at gray_addr, 1-cycle latency
//  lbp_valid   in   1       engine result write strobe
//  lbp_addr    in   ADDR_W  result address
//  lbp_data    in   DATA_W  result pixel
//  finish      in   1       engine frame complete
//  rd_en       in   1       readback request (DONE only)
//  rd_addr     in   ADDR_W  readback address
//  rd_data     out  DATA_W  result pixel, 1-cycle latency
//  rd_valid    out  1       rd_data valid (rd_en delayed 1 cycle, gated by DONE)
//  done        out  1       high in DONE
//  wr_count    out  ADDR_W+1 accepted result writes, saturates at IMG_W*IMG_H
//  err         out  1       sticky protocol error
// BEHAVIOUR
//  Reset: state=IDLE; load_ready, gray_ready, done, rd_valid, err=0; gray_data, rd_data, wr_count=0.
//   Load counter cleared; RAM contents not cleared. Reset mid-operation aborts to IDLE.
//  FSM IDLE -> LOAD on start. LOAD: each load_valid writes gray RAM[load_cnt], load_cnt++.
//   Beat at load_cnt==IMG_W*IMG_H-1 -> SERVE next cycle; load_ready drops same edge.
//  SERVE: gray_ready=1. gray_req high at edge N -> gray_data = RAM[gray_addr] after edge N+1.
//   gray_req low: gray_data holds last value. Addr >= IMG_W*IMG_H: gray_data=0, err set.
//  lbp_valid in SERVE: result RAM[lbp_addr] <= lbp_data; wr_count++ (saturating).
//   Rewrite of same address allowed; counted again. Addr out of range: write dropped, err set.
//  finish in SERVE -> DONE next cycle; lbp_valid on same cycle is still accepted and counted.
//   finish with wr_count (incl. same-cycle write) != IMG_W*IMG_H sets err; still goes to DONE.
//  DONE: gray_ready=0, done=1; rd_en samples rd_addr, rd_data/rd_valid next cycle.
//   start in DONE -> LOAD (new frame); wr_count cleared, done drops; err kept until reset.
//  Protocol errors (err=1): lbp_valid or finish outside SERVE; gray_req outside SERVE;
//   start in LOAD/SERVE (ignored). load_valid outside LOAD ignored, no error.
//  rd_en outside DONE: rd_valid stays 0, rd_data holds.
// STRUCTURE
//  lbp_pkg: IMG_W, IMG_H, PIX_N=IMG_W*IMG_H, ADDR_W, DATA_W, state enum {IDLE,LOAD,SERVE,DONE}.
//  Sub-module lbp_frame_ram: 1 write port, 1 registered read port, PIX_N x DATA_W;
//   two instances (gray frame, result frame). Result RAM read port muxed: unused in SERVE, rd_* in DONE.
//  Top holds FSM, load counter, wr_count, err logic, output registers.
// TESTING
//  Reset -> all outputs 0, state IDLE; start, 16384 beats load_data=addr[7:0] -> gray_ready rises cycle after last beat.
//  SERVE: gray_req=1, gray_addr=0x0101 -> gray_data=0x01 one cycle later; gray_req=0 -> gray_data holds 0x01.
//  16384 lbp_valid writes data=addr^0xA5 then finish -> done=1, wr_count=16384, err=0; rd_addr=0x0080 -> rd_data=0x25, rd_valid=1.
//  finish after 100 writes -> DONE, wr_count=100, err=1; lbp_valid+finish same cycle at count 16383 -> wr_count=16384, err=0.
//  lbp_valid in LOAD -> err=1, result RAM unchanged; start during SERVE -> ignored, err=1.
//  reset asserted mid-LOAD at beat 5000 -> IDLE, load_ready=0; fresh start reloads from addr 0.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared sizes, FSM state type and address check for the LBP frame host.
package lbp_pkg;

    localparam int unsigned IMG_W  = 128;
    localparam int unsigned IMG_H  = 128;
    localparam int unsigned PIX_N  = IMG_W * IMG_H;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StServe,
        StDone
    } state_e;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < PIX_N;
    endfunction

endpackage

// File: rtl/lbp_frame_ram.sv
// Single-port-write frame buffer with one registered read port; contents survive reset.
module lbp_frame_ram
    import lbp_pkg::*;
#(
    parameter int unsigned Depth = PIX_N,
    parameter int unsigned AddrW = ADDR_W,
    parameter int unsigned DataW = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [DataW-1:0] wdata,
    input  logic             re,
    input  logic [AddrW-1:0] raddr,
    output logic [DataW-1:0] rdata
);

    logic [DataW-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset so outputs start at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lbp_frame_host.sv
// Host side of the LBP engine interface: loads a gray frame, serves it, captures results,
// and offers the result frame for readback once the engine signals finish.
module lbp_frame_host
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIX_N - 1);
    localparam logic [ADDR_W:0]   FullCnt  = (ADDR_W + 1)'(PIX_N);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   load_cnt_q, load_cnt_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic                err_q, err_d;
    logic                gray_oor_q, gray_oor_d;
    logic                rd_valid_q, rd_valid_d;
    logic                gray_we, gray_re, res_we, res_re;
    logic [DATA_W-1:0]   gray_q, res_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
            gray_oor_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            gray_oor_q <= gray_oor_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        gray_oor_d = gray_oor_q;
        rd_valid_d = 1'b0;
        gray_we    = 1'b0;
        gray_re    = 1'b0;
        res_we     = 1'b0;
        res_re     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                    wr_count_d = '0;
                end
            end
            StLoad: begin
                if (start) err_d = 1'b1;
                if (load_valid) begin
                    gray_we    = 1'b1;
                    load_cnt_d = load_cnt_q + ADDR_W'(1);
                    if (load_cnt_q == LastAddr) state_d = StServe;
                end
            end
            StServe: begin
                if (start) err_d = 1'b1;
                if (gray_req) begin
                    if (addr_ok(gray_addr)) begin
                        gray_re    = 1'b1;
                        gray_oor_d = 1'b0;
                    end else begin
                        gray_oor_d = 1'b1;
                        err_d      = 1'b1;
                    end
                end
                if (lbp_valid) begin
                    if (addr_ok(lbp_addr)) begin
                        res_we = 1'b1;
                        if (wr_count_q != FullCnt) wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A write landing in the finish cycle counts toward completeness.
                if (finish) begin
                    state_d = StDone;
                    if (wr_count_d != FullCnt) err_d = 1'b1;
                end
            end
            StDone: begin
                if (start) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                    wr_count_d = '0;
                end
                if (rd_en) begin
                    res_re     = addr_ok(rd_addr);
                    rd_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StServe && (lbp_valid || finish || gray_req)) err_d = 1'b1;
    end

    lbp_frame_ram u_gray_ram (
        .clk   (clk),
        .reset (reset),
        .we    (gray_we),
        .waddr (load_cnt_q),
        .wdata (load_data),
        .re    (gray_re),
        .raddr (gray_addr),
        .rdata (gray_q)
    );

    // Result RAM is only read back in DONE, so its read port belongs to rd_*.
    lbp_frame_ram u_res_ram (
        .clk   (clk),
        .reset (reset),
        .we    (res_we),
        .waddr (lbp_addr),
        .wdata (lbp_data),
        .re    (res_re),
        .raddr (rd_addr),
        .rdata (res_q)
    );

    assign load_ready = (state_q == StLoad);
    assign gray_ready = (state_q == StServe);
    assign done       = (state_q == StDone);
    assign gray_data  = gray_oor_q ? '0 : gray_q;
    assign rd_data    = res_q;
    assign rd_valid   = rd_valid_q;
    assign wr_count   = wr_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lbp_frame_host.sv
// Self-checking bench for lbp_frame_host: table-driven reads with a scoreboard queue plus
// hand-written sequences for load/finish/reset corner cases.
module tb_lbp_frame_host;
    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [DATA_W-1:0] gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              err;

    lbp_frame_host dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .wr_count   (wr_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } rd_vec_t;

    rd_vec_t gray_tab [5];
    rd_vec_t res_tab  [4];
    logic [DATA_W-1:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_beats(input int n, input logic [7:0] xr, input bit full);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i) ^ xr;
            if (full && i == int'(PIX_N) - 1) begin
                check("gray_ready_before_last_beat", {31'b0, gray_ready}, 32'd0);
                check("load_ready_at_last_beat", {31'b0, load_ready}, 32'd1);
            end
            tick();
        end
        load_valid = 1'b0;
        if (full) begin
            check("gray_ready_after_load", {31'b0, gray_ready}, 32'd1);
            check("load_ready_after_load", {31'b0, load_ready}, 32'd0);
        end
    endtask

    task automatic write_range(input int first, input int n, input bit use_xor);
        for (int i = first; i < first + n; i++) begin
            lbp_valid = 1'b1;
            lbp_addr  = ADDR_W'(i);
            lbp_data  = use_xor ? (8'(i) ^ 8'hA5) : 8'h11;
            tick();
        end
        lbp_valid = 1'b0;
    endtask

    task automatic gray_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        gray_req  = 1'b1;
        gray_addr = a;
        exp_q.push_back(e);
        tick();
        gray_req = 1'b0;
        check($sformatf("gray_data@%0h", a), {24'b0, gray_data}, {24'b0, exp_q.pop_front()});
    endtask

    task automatic res_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
        check($sformatf("rd_data@%0h", a), {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
        check($sformatf("rd_valid@%0h", a), {31'b0, rd_valid}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load_ready"}, {31'b0, load_ready}, 32'd0);
        check({tag, "_gray_ready"}, {31'b0, gray_ready}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_wr_count"}, {17'b0, wr_count}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    initial begin
        gray_tab[0] = '{14'h0101, 8'h01};
        gray_tab[1] = '{14'h0000, 8'h00};
        gray_tab[2] = '{14'h3FFF, 8'hFF};
        gray_tab[3] = '{14'h1388, 8'h88};
        gray_tab[4] = '{14'h0080, 8'h80};
        res_tab[0]  = '{14'h0080, 8'h25};
        res_tab[1]  = '{14'h0000, 8'hA5};
        res_tab[2]  = '{14'h3FFF, 8'h5A};
        res_tab[3]  = '{14'h0101, 8'hA4};

        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
        gray_req = 1'b0; gray_addr = '0; lbp_valid = 1'b0; lbp_addr = '0;
        lbp_data = '0; finish = 1'b0; rd_en = 1'b0; rd_addr = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset_gray_data", {24'b0, gray_data}, 32'd0);
        check("reset_rd_data", {24'b0, rd_data}, 32'd0);
        reset = 1'b0;

        // Abort a load midway; the next load must restart at address 0.
        start = 1'b1; tick(); start = 1'b0;
        check("load_ready_in_load", {31'b0, load_ready}, 32'd1);
        load_beats(5000, 8'h00, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        check_idle_outputs("midload_reset");

        start = 1'b1; tick(); start = 1'b0;
        load_beats(int'(PIX_N), 8'h00, 1'b1);
        foreach (gray_tab[i]) gray_read(gray_tab[i].addr, gray_tab[i].exp);
        gray_read(14'h0101, 8'h01);
        tick();
        tick();
        check("gray_data_hold", {24'b0, gray_data}, 32'h01);

        // Full frame, final write in the same cycle as finish.
        write_range(0, int'(PIX_N) - 1, 1'b1);
        check("wr_count_before_final", {17'b0, wr_count}, 32'd16383);
        check("done_before_finish", {31'b0, done}, 32'd0);
        lbp_valid = 1'b1; lbp_addr = 14'h3FFF; lbp_data = 8'h5A; finish = 1'b1;
        tick();
        lbp_valid = 1'b0; finish = 1'b0;
        check("full_done", {31'b0, done}, 32'd1);
        check("full_gray_ready", {31'b0, gray_ready}, 32'd0);
        check("full_wr_count", {17'b0, wr_count}, 32'd16384);
        check("full_err", {31'b0, err}, 32'd0);
        foreach (res_tab[i]) res_read(res_tab[i].addr, res_tab[i].exp);
        tick();
        check("rd_valid_drops", {31'b0, rd_valid}, 32'd0);

        // New frame from DONE; short result frame.
        start = 1'b1; tick(); start = 1'b0;
        check("restart_done", {31'b0, done}, 32'd0);
        check("restart_load_ready", {31'b0, load_ready}, 32'd1);
        check("restart_wr_count", {17'b0, wr_count}, 32'd0);
        load_beats(int'(PIX_N), 8'h3C, 1'b1);
        gray_read(14'h0101, 8'h3D);
        rd_en = 1'b1; rd_addr = 14'h0000; tick(); rd_en = 1'b0;
        check("rd_valid_outside_done", {31'b0, rd_valid}, 32'd0);
        check("rd_data_hold_outside_done", {24'b0, rd_data}, 32'hA4);
        check("err_before_bad_start", {31'b0, err}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("start_in_serve_err", {31'b0, err}, 32'd1);
        check("start_in_serve_ignored", {31'b0, gray_ready}, 32'd1);
        write_range(0, 100, 1'b0);
        finish = 1'b1; tick(); finish = 1'b0;
        check("short_done", {31'b0, done}, 32'd1);
        check("short_wr_count", {17'b0, wr_count}, 32'd100);
        check("short_err", {31'b0, err}, 32'd1);
        res_read(14'h0005, 8'h11);
        res_read(14'h0080, 8'h25);

        // Result write during LOAD must be dropped and flagged.
        reset = 1'b1; tick(); reset = 1'b0;
        check_idle_outputs("reset2");
        start = 1'b1; tick(); start = 1'b0;
        lbp_valid = 1'b1; lbp_addr = 14'h0080; lbp_data = 8'h00; tick(); lbp_valid = 1'b0;
        check("lbp_in_load_err", {31'b0, err}, 32'd1);
        load_beats(int'(PIX_N), 8'h00, 1'b1);
        finish = 1'b1; tick(); finish = 1'b0;
        check("empty_done", {31'b0, done}, 32'd1);
        check("empty_wr_count", {17'b0, wr_count}, 32'd0);
        res_read(14'h0080, 8'h25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
